// File: rtl/rsa_pkg.sv
// Shared types and constants for the RSA round-trip self-check controller.
// Holds the controller state encoding, result status codes and default operand sizing.
package rsa_pkg;

    localparam int RSA_N_BIT = 12;
    localparam int RSA_N     = 3551;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ENC     = 3'd1,
        DEC     = 3'd2,
        RELEASE = 3'd3,
        REPORT  = 3'd4
    } state_t;

    localparam logic [1:0] ST_MATCH    = 2'd0;
    localparam logic [1:0] ST_MISMATCH = 2'd1;
    localparam logic [1:0] ST_RANGE    = 2'd2;
    localparam logic [1:0] ST_TIMEOUT  = 2'd3;

endpackage

// File: rtl/rsa_watchdog.sv
// Per-phase watchdog for the round-trip controller: cleared on phase entry, counts while
// enabled, and flags expiry once the phase has lasted TIMEOUT cycles.
module rsa_watchdog #(
    parameter int TIMEOUT = 8191
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: clear wins, counting parks at the expiry value.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = {CW{1'b0}};
        end else if (enable_i && (cnt_q != LAST)) begin
            cnt_d = cnt_q + 1'b1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= {CW{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = enable_i && (cnt_q == LAST);

endmodule

// File: rtl/rsa_roundtrip_ctrl.sv
// Round-trip self-check: encrypts an accepted plaintext, decrypts the ciphertext, and
// reports plain/cipher/status on a valid/ready result port with saturating tallies.
module rsa_roundtrip_ctrl
    import rsa_pkg::*;
#(
    parameter int N_BIT   = RSA_N_BIT,
    parameter int N       = RSA_N,
    parameter int TIMEOUT = 8191,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N_BIT-1:0] in_data,
    output logic             enc_start,
    output logic [N_BIT-1:0] enc_data_in,
    input  logic [N_BIT-1:0] enc_data_out,
    input  logic             enc_done,
    output logic             dec_start,
    output logic [N_BIT-1:0] dec_data_in,
    input  logic [N_BIT-1:0] dec_data_out,
    input  logic             dec_done,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N_BIT-1:0] out_plain,
    output logic [N_BIT-1:0] out_cipher,
    output logic [1:0]       out_status,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic             busy
);

    localparam logic [N_BIT:0]   N_LIM   = (N_BIT + 1)'(N);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    state_t           state_q, state_d;
    logic [N_BIT-1:0] plain_q, plain_d;
    logic [N_BIT-1:0] cipher_q, cipher_d;
    logic [1:0]       status_q, status_d;
    logic [CNT_W-1:0] pass_q, pass_d;
    logic [CNT_W-1:0] fail_q, fail_d;
    logic             seen_low_q, seen_low_d;
    logic             in_ready_q, enc_start_q, dec_start_q, out_valid_q, busy_q;
    logic             wd_clear_s, wd_enable_s, wd_expired_s;
    logic             in_range_s;

    assign in_range_s  = ({1'b0, in_data} < N_LIM);
    assign wd_enable_s = (state_q == ENC) || (state_q == DEC);

    rsa_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_i   (wd_clear_s),
        .enable_i  (wd_enable_s),
        .expired_o (wd_expired_s)
    );

    // Next-state and datapath decisions. seen_low_q guards against a done left high from
    // an earlier phase: done is only honoured after it has been sampled low in this phase.
    always_comb begin
        state_d    = state_q;
        plain_d    = plain_q;
        cipher_d   = cipher_q;
        status_d   = status_q;
        pass_d     = pass_q;
        fail_d     = fail_q;
        seen_low_d = seen_low_q;
        wd_clear_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    plain_d  = in_data;
                    cipher_d = {N_BIT{1'b0}};
                    if (in_range_s) begin
                        state_d    = ENC;
                        wd_clear_s = 1'b1;
                        seen_low_d = 1'b0;
                    end else begin
                        status_d = ST_RANGE;
                        state_d  = REPORT;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ENC: begin
                seen_low_d = seen_low_q | ~enc_done;
                if (enc_done && seen_low_q) begin
                    cipher_d   = enc_data_out;
                    state_d    = DEC;
                    wd_clear_s = 1'b1;
                    seen_low_d = 1'b0;
                end else if (wd_expired_s) begin
                    status_d = ST_TIMEOUT;
                    state_d  = RELEASE;
                end else begin
                    state_d = ENC;
                end
            end
            DEC: begin
                seen_low_d = seen_low_q | ~dec_done;
                if (dec_done && seen_low_q) begin
                    status_d = (dec_data_out == plain_q) ? ST_MATCH : ST_MISMATCH;
                    state_d  = RELEASE;
                end else if (wd_expired_s) begin
                    status_d = ST_TIMEOUT;
                    state_d  = RELEASE;
                end else begin
                    state_d = DEC;
                end
            end
            RELEASE: begin
                if (!enc_done && !dec_done) begin
                    state_d = REPORT;
                end else begin
                    state_d = RELEASE;
                end
            end
            REPORT: begin
                if (out_valid_q && out_ready) begin
                    if (status_q == ST_MATCH) begin
                        pass_d = sat_inc(pass_q);
                    end else begin
                        fail_d = sat_inc(fail_q);
                    end
                    state_d = IDLE;
                end else begin
                    state_d = REPORT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, datapath and registered handshake outputs decoded from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            plain_q     <= {N_BIT{1'b0}};
            cipher_q    <= {N_BIT{1'b0}};
            status_q    <= 2'd0;
            pass_q      <= {CNT_W{1'b0}};
            fail_q      <= {CNT_W{1'b0}};
            seen_low_q  <= 1'b0;
            in_ready_q  <= 1'b0;
            enc_start_q <= 1'b0;
            dec_start_q <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            plain_q     <= plain_d;
            cipher_q    <= cipher_d;
            status_q    <= status_d;
            pass_q      <= pass_d;
            fail_q      <= fail_d;
            seen_low_q  <= seen_low_d;
            in_ready_q  <= (state_d == IDLE);
            enc_start_q <= (state_d == ENC);
            dec_start_q <= (state_d == DEC);
            out_valid_q <= (state_d == REPORT);
            busy_q      <= (state_d != IDLE);
        end
    end

    assign in_ready    = in_ready_q;
    assign enc_start   = enc_start_q;
    assign enc_data_in = plain_q;
    assign dec_start   = dec_start_q;
    assign dec_data_in = cipher_q;
    assign out_valid   = out_valid_q;
    assign out_plain   = plain_q;
    assign out_cipher  = cipher_q;
    assign out_status  = status_q;
    assign pass_cnt    = pass_q;
    assign fail_cnt    = fail_q;
    assign busy        = busy_q;

endmodule
